// File: rtl/uart_rx_if.sv
// Register-side bundle of the UART receiver: line, sample strobe, frame config and FIFO head/status.
// slave is the receiver's view; master is the register block / line driver view.
interface uart_rx_if #(
    parameter int UART_DATA_WIDTH = 8
);
    logic                       rx_sample_pulse;
    logic                       UART_RX;
    logic                       data_bits;
    logic                       parity_en;
    logic                       parity_odd0_even1;
    logic                       rx_data_reg_rd;
    logic                       rx_err_clr;
    logic [UART_DATA_WIDTH-1:0] rx_data;
    logic                       rx_parity_err;
    logic                       rx_frame_err;
    logic                       rx_valid;
    logic                       rx_full;
    logic                       rx_overrun;

    modport slave (
        input  rx_sample_pulse, UART_RX, data_bits, parity_en, parity_odd0_even1,
               rx_data_reg_rd, rx_err_clr,
        output rx_data, rx_parity_err, rx_frame_err, rx_valid, rx_full, rx_overrun
    );

    modport master (
        output rx_sample_pulse, UART_RX, data_bits, parity_en, parity_odd0_even1,
               rx_data_reg_rd, rx_err_clr,
        input  rx_data, rx_parity_err, rx_frame_err, rx_valid, rx_full, rx_overrun
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 7/8-bit framing, parity and stop check, show-ahead FIFO; UART_RX_MAJORITY_EN adds 3-sample voting.
// rx_valid rises one cycle after the stop-bit sample; no backpressure, a full FIFO drops the frame and sets sticky rx_overrun.
module uart_rx #(
    parameter int UART_DATA_WIDTH        = 8,
    parameter int UART_RX_FIFO_DEPTH     = 8,
    parameter int UART_RX_FIFO_PTR_WIDTH = 4
) (
    input  logic     ACLK,
    input  logic     ARESET,
    uart_rx_if.slave rx_if
);
    localparam int DW = UART_DATA_WIDTH;
    localparam int EW = UART_DATA_WIDTH + 2;
    localparam int AW = UART_RX_FIFO_PTR_WIDTH - 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] START_TICK = 4'd8;
`else
    localparam logic [3:0] START_TICK = 4'd7;
`endif

    state_t        r_state, w_next;
    logic          r_sync1, r_sync2, r_rx_s_d;
    logic [3:0]    r_tick;
    logic [2:0]    r_bit;
    logic [DW-1:0] r_shift;
    logic          r_par_err;
    logic          w_rx_s, w_bit, w_pulse, w_tick_start, w_tick15, w_last;
    logic          w_tick_clr, w_bit_clr, w_shift_en, w_par_en, w_push;
    logic [DW-1:0] w_data;
    logic          w_exp_par;

    assign w_pulse      = rx_if.rx_sample_pulse;
    assign w_rx_s       = r_sync2;
    assign w_tick_start = (r_tick == START_TICK);
    assign w_tick15     = (r_tick == 4'hF);
    assign w_last       = (r_bit == (3'd6 + {2'b00, rx_if.data_bits}));

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_rx_s_d <= 1'b1;
        end else begin
            r_sync1 <= rx_if.UART_RX;
            r_sync2 <= r_sync1;
            if (w_pulse) r_rx_s_d <= w_rx_s;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Start bit votes over ticks 6..8, every other bit over ticks 7..9.
    logic [2:0] r_maj;
    logic       w_maj_shift;
    assign w_maj_shift = w_pulse &&
        (((r_state == S_START) && (r_tick == 4'd6 || r_tick == 4'd7)) ||
         ((r_state != S_IDLE) && (r_state != S_START) && (r_tick >= 4'd7) && (r_tick <= 4'd9)));
    always_ff @(posedge ACLK) begin
        if (ARESET)           r_maj <= 3'b000;
        else if (w_maj_shift) r_maj <= {r_maj[1:0], w_rx_s};
    end
    assign w_bit = (r_state == S_START)
                 ? ((r_maj[1] & r_maj[0]) | (r_maj[1] & w_rx_s) | (r_maj[0] & w_rx_s))
                 : ((r_maj[2] & r_maj[1]) | (r_maj[2] & r_maj[0]) | (r_maj[1] & r_maj[0]));
`else
    assign w_bit = w_rx_s;
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_pulse) begin
            case (r_state)
                S_IDLE:   if (r_rx_s_d && !w_rx_s) w_next = S_START;
                S_START:  if (w_tick_start) w_next = w_bit ? S_IDLE : S_DATA;
                S_DATA:   if (w_tick15 && w_last) w_next = rx_if.parity_en ? S_PARITY : S_STOP;
                S_PARITY: if (w_tick15) w_next = S_STOP;
                S_STOP:   if (w_tick15) w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_tick_clr = 1'b1;
        w_bit_clr  = 1'b0;
        w_shift_en = 1'b0;
        w_par_en   = 1'b0;
        w_push     = 1'b0;
        case (r_state)
            S_START: begin
                w_tick_clr = w_tick_start;
                w_bit_clr  = 1'b1;
            end
            S_DATA: begin
                w_tick_clr = 1'b0;
                w_shift_en = w_pulse && w_tick15;
            end
            S_PARITY: begin
                w_tick_clr = 1'b0;
                w_par_en   = w_pulse && w_tick15;
            end
            S_STOP: begin
                w_tick_clr = 1'b0;
                w_push     = w_pulse && w_tick15;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_tick <= 4'd0;
            r_bit  <= 3'd0;
        end else if (w_pulse) begin
            r_tick <= w_tick_clr ? 4'd0 : r_tick + 4'd1;
            if (w_bit_clr)       r_bit <= 3'd0;
            else if (w_shift_en) r_bit <= r_bit + 3'd1;
        end
    end

    // LSB-first shifting leaves a 7-bit character in the top bits; realign it.
    assign w_data    = rx_if.data_bits ? r_shift : {1'b0, r_shift[DW-1:1]};
    assign w_exp_par = rx_if.parity_odd0_even1 ? ^w_data : ~^w_data;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_shift   <= '0;
            r_par_err <= 1'b0;
        end else begin
            if (w_shift_en) r_shift <= {w_bit, r_shift[DW-1:1]};
            if (r_state == S_IDLE) r_par_err <= 1'b0;
            else if (w_par_en)     r_par_err <= (w_bit != w_exp_par);
        end
    end

    logic [EW-1:0]                 r_mem [UART_RX_FIFO_DEPTH];
    logic [UART_RX_FIFO_PTR_WIDTH-1:0] r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
    logic                          r_valid, r_full, r_overrun;
    logic                          w_pop, w_wr, w_drop;
    logic [EW-1:0]                 w_head;

    assign w_pop      = rx_if.rx_data_reg_rd && r_valid;
    assign w_wr       = w_push && (!r_full || w_pop);
    assign w_drop     = w_push && r_full && !w_pop;
    assign w_wptr_nxt = r_wptr + {{AW{1'b0}}, w_wr};
    assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_pop};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < UART_RX_FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_valid   <= 1'b0;
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) r_mem[r_wptr[AW-1:0]] <= {~w_bit, r_par_err, w_data};
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_valid <= (w_wptr_nxt != w_rptr_nxt);
            r_full  <= (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                       (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop)                r_overrun <= 1'b1;
            else if (rx_if.rx_err_clr) r_overrun <= 1'b0;
        end
    end

    assign w_head              = r_mem[r_rptr[AW-1:0]];
    assign rx_if.rx_data       = r_valid ? w_head[DW-1:0] : '0;
    assign rx_if.rx_parity_err = r_valid & w_head[DW];
    assign rx_if.rx_frame_err  = r_valid & w_head[DW+1];
    assign rx_if.rx_valid      = r_valid;
    assign rx_if.rx_full       = r_full;
    assign rx_if.rx_overrun    = r_overrun;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven at 64 clocks per bit, checked against a queue model of the FIFO.
module tb_uart_rx;
    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    uart_rx_if #(.UART_DATA_WIDTH(8)) bus ();

    uart_rx #(
        .UART_DATA_WIDTH(8),
        .UART_RX_FIFO_DEPTH(8),
        .UART_RX_FIFO_PTR_WIDTH(4)
    ) dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .rx_if(bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          pcnt   = 0;
    logic [9:0]  mq[$];
    logic [9:0]  dummy;
    bit          m_ovr   = 1'b0;
    bit          settled = 1'b0;
    logic        exp_v;
    logic [12:0] cmp_act, cmp_exp;

    initial begin
        bus.rx_sample_pulse = 1'b0;
        forever begin
            @(posedge ACLK);
            #1;
            pcnt = pcnt + 1;
            bus.rx_sample_pulse = (pcnt % 4 == 0);
        end
    end

    // Model comparison on every quiet cycle.
    always @(negedge ACLK) begin
        if (settled) begin
            exp_v   = (mq.size() != 0);
            cmp_exp = {exp_v, (mq.size() == 8), m_ovr, exp_v ? mq[0] : 10'h000};
            cmp_act = {bus.rx_valid, bus.rx_full, bus.rx_overrun,
                       bus.rx_valid ? {bus.rx_frame_err, bus.rx_parity_err, bus.rx_data} : 10'h000};
            checks++;
            if (cmp_act !== cmp_exp) begin
                errors++;
                $display("FAIL model_cmp t=%0t got %h expected %h", $time, cmp_act, cmp_exp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v, input bit glitch);
        bus.UART_RX = v;
        if (glitch) begin
            step(8);
            bus.UART_RX = ~v;
            step(4);
            bus.UART_RX = v;
            step(52);
        end else begin
            step(64);
        end
    endtask

    task automatic line_idle(input logic v, input int n);
        bus.UART_RX = v;
        settled = 1'b1;
        step(n);
    endtask

    task automatic send(input logic [7:0] d, input bit eight, input bit pen, input bit even,
                        input logic pbit, input logic sbit, input int gl_bit);
        int         nb;
        logic [7:0] dm;
        bit         perr;
        settled = 1'b0;
        bus.data_bits         = eight;
        bus.parity_en         = pen;
        bus.parity_odd0_even1 = even;
        nb = eight ? 8 : 7;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d[i], i == gl_bit);
        if (pen) drive_bit(pbit, 1'b0);
        drive_bit(sbit, 1'b0);
        dm   = eight ? d : {1'b0, d[6:0]};
        perr = pen && (pbit != (even ? ($countones(dm) % 2 == 1) : ($countones(dm) % 2 == 0)));
        if (mq.size() < 8) mq.push_back({~sbit, perr, dm});
        else               m_ovr = 1'b1;
    endtask

    task automatic pop();
        settled = 1'b0;
        bus.rx_data_reg_rd = 1'b1;
        step(1);
        bus.rx_data_reg_rd = 1'b0;
        if (mq.size() != 0) dummy = mq.pop_front();
        settled = 1'b1;
    endtask

    task automatic err_clr();
        settled = 1'b0;
        bus.rx_err_clr = 1'b1;
        step(1);
        bus.rx_err_clr = 1'b0;
        m_ovr = 1'b0;
        settled = 1'b1;
    endtask

    initial begin
        bus.UART_RX           = 1'b1;
        bus.data_bits         = 1'b1;
        bus.parity_en         = 1'b0;
        bus.parity_odd0_even1 = 1'b1;
        bus.rx_data_reg_rd    = 1'b0;
        bus.rx_err_clr        = 1'b0;
        step(3);
        ARESET = 1'b0;
        step(1);
        chk("rst_valid", bus.rx_valid, 0);
        chk("rst_full", bus.rx_full, 0);
        chk("rst_overrun", bus.rx_overrun, 0);
        chk("rst_data", bus.rx_data, 0);
        chk("rst_perr", bus.rx_parity_err, 0);
        chk("rst_ferr", bus.rx_frame_err, 0);
        line_idle(1'b1, 100);

        // 8N1 0xA5
        send(8'hA5, 1, 0, 1, 1'b0, 1'b1, -1);
        line_idle(1'b1, 20);
        chk("a5_valid", bus.rx_valid, 1);
        chk("a5_data", bus.rx_data, 8'hA5);
        chk("a5_perr", bus.rx_parity_err, 0);
        chk("a5_ferr", bus.rx_frame_err, 0);
        pop();
        chk("a5_pop_valid", bus.rx_valid, 0);

        // 7E1 0x35, correct then wrong parity bit
        send(8'h35, 0, 1, 1, 1'b0, 1'b1, -1);
        line_idle(1'b1, 20);
        chk("7e1_data", bus.rx_data, 8'h35);
        chk("7e1_perr0", bus.rx_parity_err, 0);
        pop();
        send(8'h35, 0, 1, 1, 1'b1, 1'b1, -1);
        line_idle(1'b1, 20);
        chk("7e1_data_b", bus.rx_data, 8'h35);
        chk("7e1_perr1", bus.rx_parity_err, 1);
        pop();

        // 0x3C with low stop bit, then line held low
        send(8'h3C, 1, 0, 1, 1'b0, 1'b0, -1);
        line_idle(1'b0, 64 * 12);
        chk("ferr_valid", bus.rx_valid, 1);
        chk("ferr_flag", bus.rx_frame_err, 1);
        chk("ferr_data", bus.rx_data, 8'h3C);
        pop();
        line_idle(1'b0, 64 * 4);
        chk("held_low_nofr", bus.rx_valid, 0);
        line_idle(1'b1, 200);
        send(8'h5A, 1, 0, 1, 1'b0, 1'b1, -1);
        line_idle(1'b1, 20);
        chk("after_low_data", bus.rx_data, 8'h5A);
        chk("after_low_ferr", bus.rx_frame_err, 0);
        pop();

        // 3-sample low glitch on idle line
        line_idle(1'b0, 12);
        line_idle(1'b1, 300);
        chk("glitch_nopush", bus.rx_valid, 0);

        // one-sample glitch early in data bit 2 (majority window / away from mid-bit)
        send(8'h0F, 1, 0, 1, 1'b0, 1'b1, 2);
        line_idle(1'b1, 20);
        chk("glitch_bit_data", bus.rx_data, 8'h0F);
        pop();

        // nine back-to-back frames, no reads
        line_idle(1'b1, 100);
        for (int k = 1; k <= 9; k++) begin
            send(k[7:0], 1, 0, 1, 1'b0, 1'b1, -1);
            if (k == 8) chk("full_after8", bus.rx_full, 1);
        end
        line_idle(1'b1, 50);
        chk("overrun_set", bus.rx_overrun, 1);
        chk("overrun_full", bus.rx_full, 1);
        err_clr();
        chk("overrun_clr", bus.rx_overrun, 0);
        for (int k = 1; k <= 8; k++) begin
            chk("fifo_order", bus.rx_data, k);
            pop();
        end
        chk("drained_valid", bus.rx_valid, 0);
        pop();
        chk("empty_pop_valid", bus.rx_valid, 0);
        chk("empty_pop_full", bus.rx_full, 0);

        // reset in mid-DATA of 0x55 with a stale entry queued
        send(8'h11, 1, 0, 1, 1'b0, 1'b1, -1);
        line_idle(1'b1, 50);
        chk("pre_rst_valid", bus.rx_valid, 1);
        settled = 1'b0;
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        bus.UART_RX = 1'b1;
        step(32);
        ARESET = 1'b1;
        step(2);
        ARESET = 1'b0;
        mq.delete();
        m_ovr = 1'b0;
        step(1);
        chk("mid_rst_valid", bus.rx_valid, 0);
        line_idle(1'b1, 800);
        send(8'hAA, 1, 0, 1, 1'b0, 1'b1, -1);
        line_idle(1'b1, 20);
        chk("post_rst_data", bus.rx_data, 8'hAA);
        pop();
        chk("post_rst_only", bus.rx_valid, 0);
        line_idle(1'b1, 50);

        settled = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive control block; the receive-side counterpart of the UART transmitter in the peripheral subsystem. Oversamples the serial line at 16× the bit rate, frames 7- or 8-bit characters with optional parity, checks parity and stop bit, and queues received characters with error flags in a local FIFO. The FIFO is read by the UART register block.

## Interface
- `UART_DATA_WIDTH`, default 8: character storage width.
- `UART_RX_FIFO_DEPTH`, default 8: FIFO entries (power of 2).
- `UART_RX_FIFO_PTR_WIDTH`, default 4: log2(depth)+1.
- `ACLK` in 1: clock.
- `ARESET` in 1: reset; synchronous, active-high. One clock; reset is synchronous and active-high.
- `rx_sample_pulse` in 1: one-cycle strobe at 16× baud rate.
- `UART_RX` in 1: serial input, asynchronous to `ACLK`.
- `data_bits` in 1: 0 = 7 data bits, 1 = 8 data bits.
- `parity_en` in 1: parity bit expected after data.
- `parity_odd0_even1` in 1: 1 = even, 0 = odd.
- `rx_data_reg_rd` in 1: pop head FIFO entry.
- `rx_err_clr` in 1: clear sticky overrun.
- `rx_data` out 8: head entry data; bit 7 is 0 in 7-bit mode.
- `rx_parity_err` out 1: head entry parity error.
- `rx_frame_err` out 1: head entry stop-bit error.
- `rx_valid` out 1: FIFO not empty.
- `rx_full` out 1: FIFO full.
- `rx_overrun` out 1: sticky; a frame was dropped because the FIFO was full.

## Operation
- Input synchronizer: 2 flops on `UART_RX`, both reset to 1. All decisions use the synchronized value `rx_s` and its previous sampled value `rx_s_d`, which updates on `rx_sample_pulse`.
- 4-bit tick counter and 3-bit bit counter. All state, counter and shift updates occur only on cycles where `rx_sample_pulse`=1.
- FSM: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Falling edge (`rx_s_d`=1, `rx_s`=0) moves to START with tick=0.
  - A line held low, e.g. after a break or frame error, starts nothing.
- START:
  - Tick counts to 7 (mid start bit).
  - If `rx_s`=0, go to DATA with tick=0 and bit=0.
  - Otherwise it is a false start; go to IDLE with no push.
- DATA:
  - At tick=15, sample `rx_s` into the shift register, LSB first.
  - Character complete when bit == 6+`data_bits`; then go to PARITY if `parity_en`, else STOP.
- PARITY:
  - Sample at tick=15.
  - Error if the sampled bit ≠ expected. Expected = ^data for even, ~^data for odd; data has bit 7 = 0 in 7-bit mode.
- STOP:
  - Sample at tick=15; `rx_s`=0 sets frame_err.
  - Push {frame_err, parity_err, data} and return to IDLE in the same pulse (mid stop bit). This allows back-to-back frames.
- Config inputs are sampled live. Changes mid-frame are undefined; software changes them only when the line is idle.
- FIFO:
  - Show-ahead; entry width `UART_DATA_WIDTH`+2; local storage with synchronous reset.
  - Push accepted if not full, or if a pop occurs in the same cycle.
  - If full with no pop, the frame is dropped and `rx_overrun` is set.
  - Pop when empty is ignored.
- `rx_overrun`: `rx_err_clr` clears it. A set event in the same cycle as the clear wins.

## Timing
- Reset values:
  - FSM = IDLE.
  - Counters = 0.
  - Synchronizer = 1.
  - FIFO empty.
  - Outputs: `rx_valid`=0, `rx_full`=0, `rx_overrun`=0, `rx_data`=0, `rx_parity_err`=0, `rx_frame_err`=0.
- Reset during a frame abandons it with no push. After reset, the block resynchronizes on the next falling edge.
- Line-to-detect latency: 2 `ACLK` synchronizer cycles plus up to 1 sample period.
- `rx_valid` rises 1 `ACLK` cycle after the `rx_sample_pulse` cycle that samples the stop bit.
- `rx_data` and flags update the cycle after a pop.
- `rx_full` and `rx_valid` are registered from the FIFO pointers.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each DATA, PARITY and STOP bit value is the 2-of-3 majority of samples at ticks 7, 8 and 9.
  - The state advance still occurs at tick 15.
  - START validation uses the majority at ticks 6, 7 and 8.
- Undefined: a single sample per bit, at tick 15 (start bit at tick 7), as described above.

## Test plan
- 8N1, byte 0xA5, `rx_sample_pulse` every 4 cycles:
  - `rx_valid`=1, `rx_data`=0xA5, both error flags 0.
  - Pop leaves `rx_valid`=0.
- 7E1 (`data_bits`=0, `parity_en`=1, even), char 0x35 with parity bit 0:
  - `rx_data`=0x35, `rx_parity_err`=0.
  - Repeat with parity bit 1: `rx_parity_err`=1.
- 8N1, 0x3C with stop bit driven 0:
  - `rx_frame_err`=1, `rx_data`=0x3C.
  - Line held low afterward produces no further frames until it returns high and falls again.
- 9 back-to-back bytes 0x01..0x09 with no reads:
  - `rx_full`=1 after 8 bytes; `rx_overrun`=1 after the ninth.
  - FIFO holds 0x01..0x08.
  - `rx_err_clr` clears `rx_overrun`.
- Low glitch of 3 sample periods on an idle line: returns to IDLE, no push.
  - With `UART_RX_MAJORITY_EN`, a 1-sample glitch at tick 8 of a data bit does not corrupt the byte.
- `ARESET` asserted mid-DATA of 0x55, then a clean 0xAA frame:
  - After reset, `rx_valid`=0.
  - Only 0xAA is received.
